stub_page_buffer: RTL and testbench

Per-link input buffer that sits directly downstream of the IPbus stub writer. It takes one 64-bit stub stream with its valid strobe and stores accepted stubs in a BX-paged memory: one page per bunch crossing, addressed by the 3-bit BX. It keeps a per-page stub count and offers a registered random-access read port, so the next processing stage can fetch stub *i* of BX *b* together with that page's stub count. Twenty instances are used, one per writer output link.

---
 rtl/stub_page_buffer.sv | 94 +++++++++
 tb/tb_stub_page_buffer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/stub_page_buffer.sv
// BX-paged stub buffer: one page per bunch crossing with a per-page stub count
// and a registered random-access read port returning {word, page count}.
module stub_page_buffer #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned PAGE_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en_proc,
  input  logic                     first_clk,
  input  logic [PAGE_W-1:0]        BX,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     valid_in,
  input  logic [PAGE_W+ADDR_W-1:0] read_add,
  output logic [DATA_W-1:0]        data_out,
  output logic [ADDR_W:0]          number_out,
  output logic [PAGE_W-1:0]        wr_page,
  output logic                     overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned RA_W  = PAGE_W + ADDR_W;
  localparam int unsigned NPAGE = 2 ** PAGE_W;
  localparam int unsigned DEPTH = 2 ** RA_W;
  localparam int unsigned FULL  = 2 ** ADDR_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  count [NPAGE];

  logic [PAGE_W-1:0] tgt_page;
  logic [CNT_W-1:0]  tgt_cnt;
  logic              cand;
  logic              accept;
  logic              drop;

  // Next state and write target; a first_clk cycle writes into the freshly cleared page
  always_comb begin
    state_next = state;
    tgt_page   = wr_page;
    tgt_cnt    = count[wr_page];
    cand       = 1'b0;
    accept     = 1'b0;
    drop       = 1'b0;
    if (first_clk) begin
      tgt_page = BX;
      tgt_cnt  = '0;
      if (state == IDLE) state_next = RUN;
    end
    cand   = ((state == RUN) || first_clk) && en_proc && valid_in && (data_in != '0);
    accept = cand && (tgt_cnt != CNT_W'(FULL));
    drop   = cand && (tgt_cnt == CNT_W'(FULL));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Counts, page pointer, sticky overflow and the read-first output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      number_out <= '0;
      wr_page    <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < int'(NPAGE); i++) count[PAGE_W'(i)] <= '0;
    end else begin
      data_out   <= mem[read_add];
      number_out <= count[read_add[RA_W-1:ADDR_W]];
      if (first_clk) begin
        wr_page   <= BX;
        count[BX] <= accept ? CNT_W'(1) : '0;
      end else if (accept) begin
        count[wr_page] <= tgt_cnt + CNT_W'(1);
      end
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage is deliberately not reset; readers bound accesses by the page count
  always_ff @(posedge clk) begin
    if (accept) mem[{tgt_page, tgt_cnt[ADDR_W-1:0]}] <= data_in;
  end

endmodule

// File: tb/tb_stub_page_buffer.sv
// Randomised and directed bench for stub_page_buffer against a queue-per-page model.
module tb_stub_page_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_proc;
  logic        first_clk;
  logic [2:0]  BX;
  logic [63:0] data_in;
  logic        valid_in;
  logic [8:0]  read_add;
  logic [63:0] data_out;
  logic [6:0]  number_out;
  logic [2:0]  wr_page;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  // Reference model: each page is a queue of accepted words
  logic [63:0] q [8][$];
  bit          m_run  = 1'b0;
  logic [2:0]  m_page = '0;
  bit          m_ovf  = 1'b0;

  stub_page_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .en_proc   (en_proc),
    .first_clk (first_clk),
    .BX        (BX),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .read_add  (read_add),
    .data_out  (data_out),
    .number_out(number_out),
    .wr_page   (wr_page),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 8; p++) q[p].delete();
    m_run  = 1'b0;
    m_page = '0;
    m_ovf  = 1'b0;
  endtask

  // One clock: drive inputs, predict outputs from pre-edge model state, check after the edge
  task automatic step(input logic fc, input logic [2:0] bx, input logic en, input logic v,
                      input logic [63:0] d, input logic [8:0] ra);
    int          rp;
    int          ri;
    logic [63:0] exp_num;
    logic [63:0] exp_dat;
    bit          dat_ok;
    bit          active;
    first_clk = fc;
    BX        = bx;
    en_proc   = en;
    valid_in  = v;
    data_in   = d;
    read_add  = ra;
    rp      = int'(ra[8:6]);
    ri      = int'(ra[5:0]);
    exp_num = 64'(q[rp].size());
    dat_ok  = ri < q[rp].size();
    exp_dat = dat_ok ? q[rp][ri] : '0;
    active  = m_run || fc;
    if (fc) begin
      m_run  = 1'b1;
      m_page = bx;
      q[bx].delete();
    end
    if (active && en && v && d != 0) begin
      if (q[m_page].size() < 64) q[m_page].push_back(d);
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    check("number_out", 64'(number_out), exp_num);
    if (dat_ok) check("data_out", data_out, exp_dat);
    check("wr_page", 64'(wr_page), 64'(m_page));
    check("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic async_reset_check();
    #2 reset = 1'b0;
    #1;
    check("rst data_out", data_out, 64'd0);
    check("rst number_out", 64'(number_out), 64'd0);
    check("rst wr_page", 64'(wr_page), 64'd0);
    check("rst overflow", 64'(overflow), 64'd0);
    model_reset();
    #2 reset = 1'b1;
  endtask

  initial begin
    logic [2:0] pg;
    logic [5:0] ix;
    reset = 1'b0;
    en_proc = 1'b0; first_clk = 1'b0; BX = '0;
    data_in = '0; valid_in = 1'b0; read_add = '0;
    model_reset();
    #7;
    check("init data_out", data_out, 64'd0);
    check("init number_out", 64'(number_out), 64'd0);
    check("init wr_page", 64'(wr_page), 64'd0);
    check("init overflow", 64'(overflow), 64'd0);
    #1 reset = 1'b1;

    // Writes before any first_clk are ignored
    for (int i = 0; i < 5; i++) step(1'b0, 3'd0, 1'b1, 1'b1, 64'(i + 1), 9'd0);
    step(1'b0, 3'd0, 1'b0, 1'b0, 64'd0, 9'd0);
    check("idle count p0", 64'(number_out), 64'd0);

    // Basic write/read on BX 3
    step(1'b1, 3'd3, 1'b1, 1'b1, 64'h1, 9'd0);
    for (int i = 2; i <= 4; i++) step(1'b0, 3'd0, 1'b1, 1'b1, 64'(i), 9'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 3'd0, 1'b1, 1'b0, 64'd0, {3'd3, 6'(i)});
      check("bx3 word", data_out, 64'(i + 1));
    end
    check("bx3 count", 64'(number_out), 64'd4);

    // Zero words and disabled cycles are filtered
    step(1'b1, 3'd4, 1'b1, 1'b1, 64'd0, 9'd0);
    step(1'b0, 3'd0, 1'b0, 1'b1, 64'hA, 9'd0);
    step(1'b0, 3'd0, 1'b1, 1'b0, 64'd0, {3'd4, 6'd0});
    check("bx4 count", 64'(number_out), 64'd0);

    // Page switch and reuse
    step(1'b1, 3'd5, 1'b1, 1'b1, 64'h51, 9'd0);
    step(1'b0, 3'd0, 1'b1, 1'b1, 64'h52, 9'd0);
    step(1'b0, 3'd0, 1'b1, 1'b1, 64'h53, 9'd0);
    step(1'b1, 3'd6, 1'b1, 1'b1, 64'h61, {3'd5, 6'd0});
    check("bx5 count pre", 64'(number_out), 64'd3);
    for (int b = 7; b <= 12; b++) step(1'b1, 3'(b), 1'b1, 1'b1, 64'(b * 16 + 1), 9'd0);
    step(1'b1, 3'd5, 1'b1, 1'b0, 64'd0, {3'd6, 6'd0});
    check("bx6 count", 64'(number_out), 64'd1);
    step(1'b0, 3'd0, 1'b1, 1'b0, 64'd0, {3'd5, 6'd0});
    check("bx5 reused", 64'(number_out), 64'd0);

    // Overflow: 70 words into BX 2, reading entries back as they fill
    step(1'b1, 3'd2, 1'b1, 1'b1, 64'd1, 9'd0);
    for (int i = 2; i <= 70; i++) step(1'b0, 3'd0, 1'b1, 1'b1, 64'(i), {3'd2, 6'(i - 2)});
    for (int i = 0; i < 64; i += 9) begin
      step(1'b0, 3'd0, 1'b1, 1'b0, 64'd0, {3'd2, 6'(i)});
      check("bx2 word", data_out, 64'(i + 1));
    end
    check("bx2 full count", 64'(number_out), 64'd64);
    step(1'b1, 3'd0, 1'b1, 1'b0, 64'd0, 9'd0);
    check("overflow sticky", 64'(overflow), 64'd1);

    // Reset mid-burst into BX 1
    step(1'b1, 3'd1, 1'b1, 1'b1, 64'h11, 9'd0);
    step(1'b0, 3'd0, 1'b1, 1'b1, 64'h12, 9'd0);
    async_reset_check();
    step(1'b1, 3'd1, 1'b1, 1'b1, 64'h99, 9'd0);
    step(1'b0, 3'd0, 1'b1, 1'b0, 64'd0, {3'd1, 6'd0});
    step(1'b0, 3'd0, 1'b1, 1'b0, 64'd0, {3'd1, 6'd0});
    check("bx1 after reset", 64'(number_out), 64'd1);
    check("bx1 word", data_out, 64'h99);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      pg = 3'($urandom);
      ix = (q[pg].size() > 0) ? 6'($urandom_range(0, q[pg].size() - 1)) : 6'($urandom);
      step(($urandom_range(0, 15) == 0), 3'($urandom), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom}, {pg, ix});
      if (n == 750) async_reset_check();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
